div_ctrl: RTL and testbench
===========================

# div_ctrl

Multi-cycle divider sequencer for the execute stage: accepts a 32-bit signed or unsigned divide request and runs a restoring shift-subtract loop at one quotient bit per cycle. It returns `{remainder, quotient}` as a 64-bit word that the execute stage writes to HI/LO. The pipeline is held for the whole operation, using the `start_i`/`ready_o` handshake and the `busy_o` indication. The block sits beside the ALU and owns the only divider resource in the core.

## Interface
Parameters:
- `DATA_W`, default 32: operand width; the iteration count equals `DATA_W`.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `start_i`  in  1  divide request; held high by the execute stage until `ready_o` is seen.
- `annul_i`  in  1  cancel; used on a pipeline flush.
- `signed_i`  in  1  1 = DIV, 0 = DIVU; sampled with `start_i`.
- `opdata1_i`  in  DATA_W  dividend; sampled with `start_i`.
- `opdata2_i`  in  DATA_W  divisor; sampled with `start_i`.
- `result_o`  out  2*DATA_W  `{remainder, quotient}`; valid while `ready_o` is high, zero otherwise.
- `ready_o`  out  1  result valid.
- `busy_o`  out  1  operation in progress (BYZERO or ON).

## Operation
- States: IDLE, BYZERO, ON, END. Reset forces IDLE, clears the iteration counter and working registers, and drives `result_o=0`, `ready_o=0`, `busy_o=0`.
- **IDLE**
  - `annul_i` has priority over `start_i`: annulled requests are ignored.
  - `start_i` with divisor 0 → BYZERO.
  - `start_i` otherwise → ON. On entry, latch `|dividend|` and `|divisor|` (magnitudes taken only when `signed_i` is set), latch both operand signs, and clear the counter.
- **BYZERO** → END with the result forced to 0 (quotient 0, remainder 0).
- **ON**, each cycle:
  - Shift the partial remainder left one bit and bring in the next dividend bit (MSB first).
  - Compute a 33-bit trial subtract of the divisor.
  - If non-negative: keep the difference and shift in quotient bit 1. Otherwise: keep the shifted value and shift in 0.
  - Increment the counter.
  - After iteration `DATA_W-1`, apply sign fix-up, register the result and go to END:
    - Quotient is negated when the signs differ (signed only).
    - Remainder takes the sign of the dividend.
- `annul_i` in ON or BYZERO → IDLE at the next edge. No result is produced and `ready_o` stays 0.
- **END**
  - `ready_o=1` and `result_o` is held stable.
  - When `start_i` is low, or `annul_i` is high → IDLE, clearing `ready_o` and `result_o`.
- Overflow case `0x80000000 / 0xFFFFFFFF` signed: quotient `0x80000000`, remainder 0, the natural wrap. No exception is raised.
- A request that arrives while the block is not in IDLE is ignored until the block returns to IDLE.

## Timing
- Edge numbering: edge 0 is the edge that samples `start_i` in IDLE.
- Normal divide:
  - Iterations on edges 1..32.
  - `ready_o` is high after edge 32, so the result is seen in the 33rd cycle after request.
  - `busy_o` is high after edges 0..31.
- Divide by zero: BYZERO after edge 0, END after edge 1. `ready_o` is high after edge 1.
- The release edge (first edge in END with `start_i` low) clears `ready_o`. A new `start_i` is accepted at the edge after that.
- All outputs are registered; there is no combinational path from input to output.
- `rst` mid-operation takes effect at the next edge, overriding `annul_i` and `start_i`.

## Configuration
- **`DIV_EARLY_EXIT_EN` defined:**
  - In IDLE, when `|dividend| < |divisor|` and the divisor is non-zero, go directly to END.
  - Quotient is 0 and remainder is the original dividend, with its sign preserved.
  - `ready_o` is high after edge 0.
  - The comparator is compiled in.
- **`DIV_EARLY_EXIT_EN` undefined:** every non-zero divisor takes the full 32 iterations, and the result is identical.

## Structure
- Shared package holds:
  - the state encoding (`DIV_IDLE`, `DIV_BYZERO`, `DIV_ON`, `DIV_END`, 2 bits);
  - `DivResultReady` / `DivResultNotReady`;
  - `DivStart` / `DivStop`;
  - `DoubleRegBus` width constants.
  These are reused by the execute stage and the stall controller.
- One sub-module, `div_step`: a combinational single restoring iteration taking partial remainder, divisor and next dividend bit, and producing the next partial remainder and the quotient bit. It is instantiated once.

## Test plan
- Unsigned 100 / 7 → `result_o = {0x00000002, 0x0000000E}`. `ready_o` rises after edge 32 and `busy_o` is high throughout the iterations.
- Signed −7 / 2 (`0xFFFFFFF9` / `0x00000002`) → quotient `0xFFFFFFFD`, remainder `0xFFFFFFFF`.
- Divisor 0, dividend 5 → `result_o = 0`, `ready_o` high after edge 1. Dropping `start_i` returns IDLE with `ready_o = 0` after one edge.
- Annul at iteration 10 → IDLE, and `ready_o` never rises. Next unsigned `0xFFFFFFFF` / `0x10` → quotient `0x0FFFFFFF`, remainder `0xF`.
- Signed `0x80000000` / `0xFFFFFFFF` → quotient `0x80000000`, remainder 0. `rst` pulsed mid-operation → all outputs 0 after the edge.
- 3 / 10 unsigned → quotient 0, remainder 3. With `DIV_EARLY_EXIT_EN`, ready after edge 0. Without the macro, ready after edge 32.

Source files
------------

// File: rtl/div_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// div_ctrl_pkg
// Shared definitions for the multi-cycle divider and its neighbours (execute
// stage, stall controller): sequencer state encoding, result-ready and
// start/stop handshake levels, and the single/double register bus widths.
// -----------------------------------------------------------------------------
package div_ctrl_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'b00,
      DIV_BYZERO = 2'b01,
      DIV_ON     = 2'b10,
      DIV_END    = 2'b11
   } div_state_e;

   localparam logic DivResultReady    = 1'b1;
   localparam logic DivResultNotReady = 1'b0;
   localparam logic DivStart          = 1'b1;
   localparam logic DivStop           = 1'b0;

   localparam int RegBus       = 32;
   localparam int DoubleRegBus = 64;

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational restoring-division iteration.
// Ports:
//   rem      partial remainder (always < divisor on entry)
//   divisor  divisor magnitude
//   in_bit   next dividend bit, MSB first
//   rem_next partial remainder after this iteration
//   q_bit    quotient bit produced by this iteration
// -----------------------------------------------------------------------------
import div_ctrl_pkg::*;

module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic [DATA_W-1:0] divisor,
   input  logic              in_bit,
   output logic [DATA_W-1:0] rem_next,
   output logic              q_bit
);

   logic [DATA_W:0] shifted;
   logic [DATA_W:0] trial;

   // rem < divisor guarantees shifted < 2*divisor, so the MSB of the
   // (DATA_W+1)-bit trial difference is an exact sign bit and the kept value
   // always fits back into DATA_W bits.
   always_comb begin
      shifted = {rem, in_bit};
      trial   = shifted - {1'b0, divisor};
      if (!trial[DATA_W]) begin
         rem_next = trial[DATA_W-1:0];
         q_bit    = 1'b1;
      end else begin
         rem_next = shifted[DATA_W-1:0];
         q_bit    = 1'b0;
      end
   end

endmodule

// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
// Multi-cycle divide sequencer (DIV / DIVU), one quotient bit per cycle using
// a restoring shift-subtract loop. Returns {remainder, quotient} for HI/LO.
// Optional build macro: DIV_EARLY_EXIT_EN -- when defined, a request whose
// dividend magnitude is below the divisor magnitude completes at once.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start_i      divide request, held until ready_o
//   annul_i      cancel (pipeline flush), wins over start_i
//   signed_i     1 = signed divide, sampled with start_i
//   opdata1_i    dividend, sampled with start_i
//   opdata2_i    divisor, sampled with start_i
//   result_o     {remainder, quotient}, zero unless ready_o
//   ready_o      result valid
//   busy_o       divide in progress
// -----------------------------------------------------------------------------
import div_ctrl_pkg::*;

module div_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start_i,
   input  logic                annul_i,
   input  logic                signed_i,
   input  logic [DATA_W-1:0]   opdata1_i,
   input  logic [DATA_W-1:0]   opdata2_i,
   output logic [2*DATA_W-1:0] result_o,
   output logic                ready_o,
   output logic                busy_o
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   div_state_e        state;
   logic [CNT_W-1:0]  cnt;
   logic [DATA_W-1:0] rem;
   // Holds the remaining dividend bits in its upper part and the quotient
   // bits collected so far in its lower part; after DATA_W shifts it is
   // entirely quotient.
   logic [DATA_W-1:0] quo_dvd;
   logic [DATA_W-1:0] divisor;
   logic              sign_a;
   logic              sign_b;

   logic              neg_a;
   logic              neg_b;
   logic [DATA_W-1:0] abs_a;
   logic [DATA_W-1:0] abs_b;
   logic [DATA_W-1:0] rem_next;
   logic              q_bit;
   logic [DATA_W-1:0] q_final;
   logic [DATA_W-1:0] r_final;
   logic              last_iter;

   // Two's-complement negate when requested; -2^(W-1) wraps onto itself,
   // which gives the natural overflow result.
   function automatic logic [DATA_W-1:0] cond_negate(input logic [DATA_W-1:0] v,
                                                     input logic              neg);
      return neg ? ('0 - v) : v;
   endfunction

   always_comb begin
      neg_a     = signed_i && ($signed(opdata1_i) < 0);
      neg_b     = signed_i && ($signed(opdata2_i) < 0);
      abs_a     = cond_negate(opdata1_i, neg_a);
      abs_b     = cond_negate(opdata2_i, neg_b);
      last_iter = (cnt == CNT_W'(DATA_W - 1));
      // Quotient negative when operand signs differ; remainder follows the
      // dividend. Signs are only latched for signed requests.
      q_final   = cond_negate({quo_dvd[DATA_W-2:0], q_bit}, sign_a ^ sign_b);
      r_final   = cond_negate(rem_next, sign_a);
   end

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem      (rem),
      .divisor  (divisor),
      .in_bit   (quo_dvd[DATA_W-1]),
      .rem_next (rem_next),
      .q_bit    (q_bit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= DIV_IDLE;
         cnt      <= '0;
         rem      <= '0;
         quo_dvd  <= '0;
         divisor  <= '0;
         sign_a   <= 1'b0;
         sign_b   <= 1'b0;
         result_o <= '0;
         ready_o  <= DivResultNotReady;
         busy_o   <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i == DivStart && !annul_i) begin
                  if (opdata2_i == '0) begin
                     state  <= DIV_BYZERO;
                     busy_o <= 1'b1;
                  end
`ifdef DIV_EARLY_EXIT_EN
                  else if (abs_a < abs_b) begin
                     state    <= DIV_END;
                     result_o <= {opdata1_i, {DATA_W{1'b0}}};
                     ready_o  <= DivResultReady;
                  end
`endif
                  else begin
                     state   <= DIV_ON;
                     busy_o  <= 1'b1;
                     cnt     <= '0;
                     rem     <= '0;
                     quo_dvd <= abs_a;
                     divisor <= abs_b;
                     sign_a  <= neg_a;
                     sign_b  <= neg_b;
                  end
               end
            end

            DIV_BYZERO: begin
               busy_o <= 1'b0;
               if (annul_i) begin
                  state <= DIV_IDLE;
               end else begin
                  state    <= DIV_END;
                  result_o <= '0;
                  ready_o  <= DivResultReady;
               end
            end

            DIV_ON: begin
               if (annul_i) begin
                  state  <= DIV_IDLE;
                  busy_o <= 1'b0;
               end else begin
                  rem     <= rem_next;
                  quo_dvd <= {quo_dvd[DATA_W-2:0], q_bit};
                  cnt     <= cnt + CNT_W'(1);
                  if (last_iter) begin
                     state    <= DIV_END;
                     busy_o   <= 1'b0;
                     result_o <= {r_final, q_final};
                     ready_o  <= DivResultReady;
                  end
               end
            end

            DIV_END: begin
               if (start_i == DivStop || annul_i) begin
                  state    <= DIV_IDLE;
                  result_o <= '0;
                  ready_o  <= DivResultNotReady;
               end
            end

            default: state <= DIV_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_ctrl
// Self-checking bench for div_ctrl: a table of divide vectors with
// hand-computed quotient/remainder, plus directed sequences for reset,
// annul (IDLE, BYZERO, ON) and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_div_ctrl;

   localparam int W = 32;
`ifdef DIV_EARLY_EXIT_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic          annul_i;
   logic          signed_i;
   logic [W-1:0]  op1;
   logic [W-1:0]  op2;
   logic [2*W-1:0] result;
   logic          ready;
   logic          busy;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic         s;
      logic [31:0]  a;
      logic [31:0]  b;
      logic [31:0]  q;
      logic [31:0]  r;
   } vec_t;

   vec_t vecs[12];

   always #5 clk = ~clk;

   div_ctrl #(.DATA_W(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .annul_i   (annul_i),
      .signed_i  (signed_i),
      .opdata1_i (op1),
      .opdata2_i (op2),
      .result_o  (result),
      .ready_o   (ready),
      .busy_o    (busy)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mag(input logic [31:0] v, input logic s);
      return (s && v[31]) ? (32'd0 - v) : v;
   endfunction

   // Edge index (edge 0 = the sampling edge) after which ready_o is expected.
   function automatic int exp_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
      if (b == 32'd0) return 1;
      if (EARLY && (mag(a, s) < mag(b, s))) return 0;
      return 32;
   endfunction

   task automatic run_div(input string name, input logic s, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eq, input logic [31:0] er);
      int   lat;
      int   n;
      logic busy_ok;
      logic [63:0] exp_res;
      lat     = exp_lat(s, a, b);
      exp_res = {er, eq};
      // Early exit returns the untouched dividend as remainder.
      signed_i = s;
      op1      = a;
      op2      = b;
      start_i  = 1'b1;
      n        = -1;
      busy_ok  = 1'b1;
      for (int k = 0; k <= 40; k++) begin
         tick;
         if (ready) begin
            n = k;
            break;
         end
         if (!busy) busy_ok = 1'b0;
      end
      check({name, " latency"}, 64'(n), 64'(lat));
      check({name, " busy during op"}, 64'(busy_ok), 64'(1));
      check({name, " result"}, result, exp_res);
      check({name, " busy at ready"}, 64'(busy), 64'(0));
      tick;
      check({name, " held ready"}, 64'(ready), 64'(1));
      check({name, " held result"}, result, exp_res);
      start_i = 1'b0;
      tick;
      check({name, " release ready"}, 64'(ready), 64'(0));
      check({name, " release result"}, result, 64'(0));
   endtask

   initial begin
      logic seen;

      vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF};
      vecs[2]  = '{1'b0, 32'd5,          32'd0,          32'h00000000, 32'h00000000};
      vecs[3]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000};
      vecs[4]  = '{1'b0, 32'd3,          32'd10,         32'h00000000, 32'h00000003};
      vecs[5]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001};
      vecs[6]  = '{1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   32'h00000003, 32'hFFFFFFFF};
      vecs[7]  = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001};
      vecs[8]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'h00000000, 32'hFFFFFFFD};
      vecs[9]  = '{1'b1, 32'h80000000,   32'd1,          32'h80000000, 32'h00000000};
      vecs[10] = '{1'b0, 32'h80000000,   32'h80000000,   32'h00000001, 32'h00000000};
      vecs[11] = '{1'b0, 32'd1000000,    32'd999,        32'd1001,     32'd1};

      rst      = 1'b1;
      start_i  = 1'b0;
      annul_i  = 1'b0;
      signed_i = 1'b0;
      op1      = '0;
      op2      = '0;
      tick;
      tick;
      check("reset result", result, 64'(0));
      check("reset ready", 64'(ready), 64'(0));
      check("reset busy", 64'(busy), 64'(0));
      rst = 1'b0;
      tick;

      for (int i = 0; i < 12; i++)
         run_div($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

      // Annul in IDLE wins over start.
      signed_i = 1'b0; op1 = 32'd100; op2 = 32'd7;
      annul_i = 1'b1; start_i = 1'b1;
      tick;
      check("annul idle busy", 64'(busy), 64'(0));
      tick;
      check("annul idle ready", 64'(ready), 64'(0));
      annul_i = 1'b0; start_i = 1'b0;
      tick;

      // Annul after ten iterations, then confirm no result ever appears.
      start_i = 1'b1;
      tick;
      repeat (10) tick;
      check("annul on busy before", 64'(busy), 64'(1));
      annul_i = 1'b1; start_i = 1'b0;
      tick;
      check("annul on busy after", 64'(busy), 64'(0));
      annul_i = 1'b0;
      seen = 1'b0;
      repeat (40) begin
         tick;
         if (ready) seen = 1'b1;
      end
      check("annul on never ready", 64'(seen), 64'(0));
      run_div("after annul", 1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'h0000000F);

      // Annul while in BYZERO.
      op1 = 32'd5; op2 = 32'd0; start_i = 1'b1;
      tick;
      check("byzero busy", 64'(busy), 64'(1));
      annul_i = 1'b1; start_i = 1'b0;
      tick;
      check("annul byzero ready", 64'(ready), 64'(0));
      check("annul byzero busy", 64'(busy), 64'(0));
      annul_i = 1'b0;
      tick;

      // Reset in the middle of the overflow case.
      signed_i = 1'b1; op1 = 32'h80000000; op2 = 32'hFFFFFFFF; start_i = 1'b1;
      tick;
      repeat (5) tick;
      rst = 1'b1; annul_i = 1'b0;
      tick;
      check("mid rst result", result, 64'(0));
      check("mid rst ready", 64'(ready), 64'(0));
      check("mid rst busy", 64'(busy), 64'(0));
      rst = 1'b0; start_i = 1'b0;
      tick;
      run_div("after rst", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
